// File: rtl/register_write_arbiter.sv
// register_write_arbiter: round-robin arbiter sequencing clears and verified writes to one shared register (optional ARB_LOCK_EN adds requester lock)
module register_write_arbiter #(
  parameter int WIDTH   = 11,
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     arb_reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock,
`endif
  output logic [NUM_REQ-1:0]       req_ack,
  input  logic                     clr_req,
  output logic                     clr_ack,
  output logic [WIDTH-1:0]         reg_in,
  output logic                     reg_wr,
  output logic                     reg_reset,
  input  logic [WIDTH-1:0]         reg_out,
  output logic                     busy,
  output logic [IDX_W-1:0]         last_grant,
  output logic                     wr_err
);
  typedef enum logic [1:0] {IDLE, WRITE, ACK, CLEAR} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, win_q, win_d, lg_q, lg_d, pick, idx;
  logic [WIDTH-1:0] reg_in_q, reg_in_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic reg_wr_q, reg_wr_d, reg_reset_q, reg_reset_d, clr_ack_q, clr_ack_d;
  logic busy_q, busy_d, wr_err_q, wr_err_d, found, relock;
  logic [WIDTH-1:0] data_a [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
    assign data_a[g] = req_data[g*WIDTH +: WIDTH];
  end
`ifdef ARB_LOCK_EN
  logic lock_q, lock_d;
  assign relock = lock_q && req_valid[win_q] && req_lock[win_q];
  // Lock is captured at ACK and released when the holder reaches IDLE without a locked request.
  always_comb begin
    lock_d = lock_q;
    if (state_q == ACK) lock_d = req_lock[win_q];
    else if (state_q == IDLE && !clr_req) lock_d = relock;
  end
  // Lock flag storage.
  always_ff @(posedge clock or negedge arb_reset)
    if (!arb_reset) lock_q <= 1'b0;
    else lock_q <= lock_d;
`else
  assign relock = 1'b0;
`endif
  // First valid requester strictly after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  // Next-state and next-output logic; every output is a registered function of the next state.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    lg_d        = lg_q;
    reg_in_d    = reg_in_q;
    wr_err_d    = wr_err_q;
    reg_wr_d    = 1'b0;
    reg_reset_d = 1'b0;
    clr_ack_d   = 1'b0;
    req_ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d     = CLEAR;
          reg_reset_d = 1'b1;
          clr_ack_d   = 1'b1;
        end else if (relock || found) begin
          state_d  = WRITE;
          win_d    = relock ? win_q : pick;
          reg_in_d = data_a[win_d];
          reg_wr_d = 1'b1;
        end
      end
      WRITE: begin
        state_d   = ACK;
        req_ack_d = NUM_REQ'(1) << win_q;
      end
      ACK: begin
        state_d  = IDLE;
        ptr_d    = win_q;
        lg_d     = win_q;
        wr_err_d = wr_err_q | (reg_out != reg_in_q);
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // State and output registers; reset drops the register strobes immediately.
  always_ff @(posedge clock or negedge arb_reset)
    if (!arb_reset) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      win_q       <= '0;
      lg_q        <= '0;
      reg_in_q    <= '0;
      req_ack_q   <= '0;
      reg_wr_q    <= 1'b0;
      reg_reset_q <= 1'b0;
      clr_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      lg_q        <= lg_d;
      reg_in_q    <= reg_in_d;
      req_ack_q   <= req_ack_d;
      reg_wr_q    <= reg_wr_d;
      reg_reset_q <= reg_reset_d;
      clr_ack_q   <= clr_ack_d;
      busy_q      <= busy_d;
      wr_err_q    <= wr_err_d;
    end
  assign req_ack    = req_ack_q;
  assign clr_ack    = clr_ack_q;
  assign reg_in     = reg_in_q;
  assign reg_wr     = reg_wr_q;
  assign reg_reset  = reg_reset_q;
  assign busy       = busy_q;
  assign last_grant = lg_q;
  assign wr_err     = wr_err_q;
endmodule
